stream_sched: RTL and testbench



---
 rtl/stream_pkg.sv | 17 +
 rtl/sample_fifo.sv | 66 ++++++
 rtl/stream_sched.sv | 241 ++++++++++++++++++++++++
 tb/tb_stream_sched.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_pkg.sv
// Shared types and constants for the UART-to-I2S sample scheduler.
package stream_pkg;

  localparam int SAMPLE_W = 24;
  localparam int CNT_W    = 16;

  localparam logic [7:0] XON_BYTE  = 8'h11;
  localparam logic [7:0] XOFF_BYTE = 8'h13;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREFILL  = 2'd1,
    ST_PLAY     = 2'd2,
    ST_UNDERRUN = 2'd3
  } state_t;

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with registered read data (1-cycle latency).
// Push is accepted on a full FIFO only when a pop happens in the same cycle;
// a pop on an empty FIFO is ignored even if a push arrives alongside it.
module sample_fifo #(
  parameter int DATA_W = 24,
  parameter int DEPTH  = 256
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   pop,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              push_ok, pop_ok;

  // Qualify push/pop against occupancy and advance pointers and count.
  always_comb begin
    pop_ok   = pop && (count_q != '0);
    push_ok  = push && ((count_q != FULL_CNT) || pop_ok);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push_ok && !pop_ok)      count_d = count_q + 1'b1;
    else if (pop_ok && !push_ok) count_d = count_q - 1'b1;
  end

  // Control state: pointers and occupancy, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage and registered read port, kept reset-free so it maps to block RAM.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
    if (pop_ok)  rd_data_q <= mem_q[rd_ptr_q];
  end

  assign rd_data = rd_data_q;
  assign full    = (count_q == FULL_CNT);
  assign empty   = (count_q == '0);
  assign count   = count_q;

endmodule

// File: rtl/stream_sched.sv
// Stream scheduler: assembles little-endian UART bytes into 24-bit samples,
// buffers them, and hands one sample per I2S frame request while sequencing
// prefill / play / underrun recovery and the DAC mute line.
// Optional XON/XOFF flow control is built when STREAM_FLOWCTL_EN is defined;
// otherwise tx_valid/tx_byte are tied to zero and tx_ready is ignored.
module stream_sched
  import stream_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int PREFILL    = 128,
  parameter int RESYNC_CYC = 27000,
  parameter int XOFF_LVL   = 224,
  parameter int XON_LVL    = 96
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [7:0]             rx_byte,
  input  logic                   rx_valid,
  input  logic                   sample_req,
  output logic [SAMPLE_W-1:0]    sample_out,
  output logic                   mute,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic [1:0]             state,
  output logic [CNT_W-1:0]       underrun_cnt,
  output logic [CNT_W-1:0]       overflow_cnt,
  output logic [7:0]             tx_byte,
  output logic                   tx_valid,
  input  logic                   tx_ready
);

  localparam int FW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(RESYNC_CYC);
  localparam logic [IW-1:0] IDLE_MAX    = IW'(RESYNC_CYC - 1);
  localparam logic [FW-1:0] PREFILL_LVL = FW'(PREFILL);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  state_t              state_q, state_d;
  logic                mute_q, mute_d;
  logic                out_en_q, out_en_d;
  logic [1:0]          phase_q, phase_d;
  logic [15:0]         lo_q, lo_d;
  logic [IW-1:0]       idle_q, idle_d;
  logic [CNT_W-1:0]    urun_q, urun_d;
  logic [CNT_W-1:0]    ovf_q, ovf_d;

  logic                push, pop;
  logic [SAMPLE_W-1:0] push_data, fifo_rd;
  logic                fifo_full, fifo_empty;
  logic [FW-1:0]       fifo_cnt;

  sample_fifo #(
    .DATA_W (SAMPLE_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push    (push),
    .wr_data (push_data),
    .pop     (pop),
    .rd_data (fifo_rd),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

  // Byte assembly with idle-timeout resync of a stale partial sample.
  always_comb begin
    phase_d   = phase_q;
    lo_d      = lo_q;
    idle_d    = idle_q;
    push      = 1'b0;
    push_data = {rx_byte, lo_q};
    if (rx_valid) begin
      idle_d = '0;
      case (phase_q)
        2'd0: begin
          lo_d[7:0] = rx_byte;
          phase_d   = 2'd1;
        end
        2'd1: begin
          lo_d[15:8] = rx_byte;
          phase_d    = 2'd2;
        end
        default: begin
          push    = 1'b1;
          phase_d = 2'd0;
        end
      endcase
    end else if (idle_q == IDLE_MAX) begin
      phase_d = 2'd0;
    end else begin
      idle_d = idle_q + 1'b1;
    end
  end

  // Playback FSM next-state, pop decision and event counters.
  always_comb begin
    state_d  = state_q;
    out_en_d = out_en_q;
    urun_d   = urun_q;
    pop      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (push) state_d = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (fifo_cnt >= PREFILL_LVL) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        if (sample_req) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            out_en_d = 1'b1;
          end else begin
            state_d  = ST_UNDERRUN;
            out_en_d = 1'b0;
            urun_d   = sat_inc(urun_q);
          end
        end
      end
      ST_UNDERRUN: begin
        if (fifo_cnt >= PREFILL_LVL) state_d = ST_PLAY;
      end
    endcase
    mute_d = (state_d != ST_PLAY);
    // A push into a full FIFO survives only if a pop frees a slot this cycle.
    ovf_d  = (push && fifo_full && !pop) ? sat_inc(ovf_q) : ovf_q;
  end

  // Control registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      mute_q   <= 1'b1;
      out_en_q <= 1'b0;
      phase_q  <= 2'd0;
      idle_q   <= '0;
      urun_q   <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      mute_q   <= mute_d;
      out_en_q <= out_en_d;
      phase_q  <= phase_d;
      idle_q   <= idle_d;
      urun_q   <= urun_d;
      ovf_q    <= ovf_d;
    end
  end

  // Partial-sample byte holding register; qualified by phase, so not reset.
  always_ff @(posedge clk) begin
    lo_q <= lo_d;
  end

  assign sample_out   = out_en_q ? fifo_rd : '0;
  assign mute         = mute_q;
  assign fill_level   = fifo_cnt;
  assign state        = state_q;
  assign underrun_cnt = urun_q;
  assign overflow_cnt = ovf_q;

`ifdef STREAM_FLOWCTL_EN
  localparam logic [FW-1:0] XOFF_FILL = FW'(XOFF_LVL);
  localparam logic [FW-1:0] XON_FILL  = FW'(XON_LVL);

  logic       xoff_sent_q, xoff_sent_d;
  logic       tx_valid_q, tx_valid_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       pend_q, pend_d;
  logic [7:0] pend_byte_q, pend_byte_d;
  logic       fc_req;
  logic [7:0] fc_byte;

  // Hysteresis on fill level plus a one-deep queue behind the byte in flight.
  always_comb begin
    xoff_sent_d = xoff_sent_q;
    fc_req      = 1'b0;
    fc_byte     = XON_BYTE;
    if (!xoff_sent_q && (fifo_cnt >= XOFF_FILL)) begin
      fc_req      = 1'b1;
      fc_byte     = XOFF_BYTE;
      xoff_sent_d = 1'b1;
    end else if (xoff_sent_q && (fifo_cnt <= XON_FILL)) begin
      fc_req      = 1'b1;
      fc_byte     = XON_BYTE;
      xoff_sent_d = 1'b0;
    end
    tx_valid_d  = tx_valid_q;
    tx_byte_d   = tx_byte_q;
    pend_d      = pend_q;
    pend_byte_d = pend_byte_q;
    if (!tx_valid_q || tx_ready) begin
      if (pend_q) begin
        tx_valid_d = 1'b1;
        tx_byte_d  = pend_byte_q;
        pend_d     = fc_req;
        if (fc_req) pend_byte_d = fc_byte;
      end else if (fc_req) begin
        tx_valid_d = 1'b1;
        tx_byte_d  = fc_byte;
      end else begin
        tx_valid_d = 1'b0;
      end
    end else if (fc_req) begin
      // A new request opposite to a queued one cancels it: the byte in
      // flight already conveys the resulting state.
      pend_d      = !pend_q;
      pend_byte_d = fc_byte;
    end
  end

  // Flow-control registers; the queued byte value is qualified by pend_q.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      xoff_sent_q <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_byte_q   <= '0;
      pend_q      <= 1'b0;
    end else begin
      xoff_sent_q <= xoff_sent_d;
      tx_valid_q  <= tx_valid_d;
      tx_byte_q   <= tx_byte_d;
      pend_q      <= pend_d;
    end
    pend_byte_q <= pend_byte_d;
  end

  assign tx_valid = tx_valid_q;
  assign tx_byte  = tx_byte_q;
`else
  logic unused_flowctl;
  assign unused_flowctl = &{1'b0, tx_ready, XOFF_LVL[0], XON_LVL[0]};
  assign tx_valid = 1'b0;
  assign tx_byte  = '0;
`endif

endmodule

// File: tb/tb_stream_sched.sv
// Bench for stream_sched: reset, prefill/play, ordered playback, underrun
// and refill, idle resync, overflow at full, flow control, mid-stream reset.
`timescale 1ns/1ps
module tb_stream_sched;

  localparam int DEPTH   = 256;
  localparam int PREFILL = 128;
  localparam int FW      = $clog2(DEPTH) + 1;
`ifdef STREAM_FLOWCTL_EN
  localparam bit FC = 1'b1;
`else
  localparam bit FC = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       rx_byte = 8'h00;
  logic             rx_valid = 1'b0;
  logic             sample_req = 1'b0;
  logic             tx_ready = 1'b0;
  logic [23:0]      sample_out;
  logic             mute;
  logic [FW-1:0]    fill_level;
  logic [1:0]       state;
  logic [15:0]      underrun_cnt;
  logic [15:0]      overflow_cnt;
  logic [7:0]       tx_byte;
  logic             tx_valid;

  int n_cmp = 0;
  int n_bad = 0;
  logic [23:0] exp_q[$];
  int          ovf_mdl = 0;
  logic [23:0] hold_v = 24'h0;
  bit          hold_valid = 1'b0;

  typedef struct {
    logic       rxv;
    logic [7:0] b;
    logic       req;
    int         fill;
    int         st;
  } vec_t;
  vec_t tbl[8];

  stream_sched dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rx_byte      (rx_byte),
    .rx_valid     (rx_valid),
    .sample_req   (sample_req),
    .sample_out   (sample_out),
    .mute         (mute),
    .fill_level   (fill_level),
    .state        (state),
    .underrun_cnt (underrun_cnt),
    .overflow_cnt (overflow_cnt),
    .tx_byte      (tx_byte),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared=%0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_mute"}, 32'(mute), 32'd1);
    chk({tag, "_sample_out"}, 32'(sample_out), 32'd0);
    chk({tag, "_fill"}, 32'(fill_level), 32'd0);
    chk({tag, "_underrun_cnt"}, 32'(underrun_cnt), 32'd0);
    chk({tag, "_overflow_cnt"}, 32'(overflow_cnt), 32'd0);
    chk({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    chk({tag, "_tx_byte"}, 32'(tx_byte), 32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_sample(input logic [23:0] v);
    send_byte(v[7:0]);
    send_byte(v[15:8]);
    send_byte(v[23:16]);
    if (exp_q.size() < DEPTH) exp_q.push_back(v);
    else ovf_mdl++;
  endtask

  // Idle for gap cycles, then one request that must pop the oldest sample.
  task automatic pop_check(input int gap);
    logic [23:0] e;
    repeat (gap) tick();
    if (hold_valid) chk("sample_hold", 32'(sample_out), 32'(hold_v));
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    e = exp_q.pop_front();
    chk("sample_out", 32'(sample_out), 32'(e));
    chk("fill_after_pop", 32'(fill_level), 32'(exp_q.size()));
    chk("state_play", 32'(state), 32'd2);
    hold_v     = e;
    hold_valid = 1'b1;
  endtask

  function automatic logic [23:0] pat(input int i, input int seed);
    return 24'(i * 40503 + seed * 7919 + 24'h0F1E2D);
  endfunction

  initial begin
    logic [23:0] v;
    logic [23:0] e;

    tbl[0] = '{1'b1, 8'hC1, 1'b0, 0, 0};
    tbl[1] = '{1'b1, 8'hC2, 1'b0, 0, 0};
    tbl[2] = '{1'b1, 8'hC3, 1'b0, 1, 1};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1, 1};
    tbl[4] = '{1'b1, 8'hD1, 1'b0, 1, 1};
    tbl[5] = '{1'b0, 8'h00, 1'b0, 1, 1};
    tbl[6] = '{1'b1, 8'hD2, 1'b0, 1, 1};
    tbl[7] = '{1'b1, 8'hD3, 1'b0, 2, 1};

    // ---------------- reset and prefill ----------------
    rst_n = 1'b0;
    tick();
    tick();
    chk_reset_vals("reset");
    rst_n = 1'b1;

    send_sample(pat(0, 1));
    chk("first_push_state", 32'(state), 32'd1);
    chk("first_push_fill", 32'(fill_level), 32'd1);
    chk("prefill_mute", 32'(mute), 32'd1);
    for (int i = 1; i < PREFILL - 1; i++) send_sample(pat(i, 1));
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("prefill_req_ignored_fill", 32'(fill_level), 32'(PREFILL - 1));
    chk("prefill_req_ignored_state", 32'(state), 32'd1);
    send_sample(pat(PREFILL - 1, 1));
    chk("prefill_full_fill", 32'(fill_level), 32'(PREFILL));
    tick();
    chk("play_state", 32'(state), 32'd2);
    chk("play_mute", 32'(mute), 32'd0);

    // ---------------- ordered playback ----------------
    for (int i = 0; i < PREFILL; i++) pop_check((i < 4) ? 561 : 3);

    // ---------------- underrun and refill ----------------
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("underrun_state", 32'(state), 32'd3);
    chk("underrun_mute", 32'(mute), 32'd1);
    chk("underrun_sample_out", 32'(sample_out), 32'd0);
    chk("underrun_cnt", 32'(underrun_cnt), 32'd1);
    hold_valid = 1'b0;
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("underrun_req_no_count", 32'(underrun_cnt), 32'd1);
    for (int i = 0; i < PREFILL - 1; i++) send_sample(pat(i, 2));
    chk("refill_still_underrun", 32'(state), 32'd3);
    send_sample(pat(PREFILL - 1, 2));
    tick();
    chk("refill_play_state", 32'(state), 32'd2);
    chk("refill_play_mute", 32'(mute), 32'd0);

    // ---------------- idle resync ----------------
    send_byte(8'hAA);
    send_byte(8'hBB);
    chk("partial_no_push", 32'(fill_level), 32'(PREFILL));
    repeat (27000) tick();
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    exp_q.push_back(24'h030201);
    chk("resync_one_push", 32'(fill_level), 32'(PREFILL + 1));
    while (exp_q.size() > 0) pop_check(2);
    sample_req = 1'b1;
    tick();
    sample_req = 1'b0;
    chk("second_underrun_cnt", 32'(underrun_cnt), 32'd2);

    // ---------------- overflow and flow control ----------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    hold_valid = 1'b0;
    ovf_mdl    = 0;
    tx_ready   = 1'b0;
    for (int i = 0; i < 224; i++) send_sample(pat(i, 3));
    chk("fill_224", 32'(fill_level), 32'd224);
    tick();
    for (int k = 0; k < 5; k++) begin
      chk("xoff_valid_held", 32'(tx_valid), 32'(FC));
      chk("xoff_byte", 32'(tx_byte), FC ? 32'h13 : 32'h0);
      tick();
    end
    for (int i = 224; i < DEPTH + 1; i++) send_sample(pat(i, 3));
    chk("full_fill", 32'(fill_level), 32'(DEPTH));
    chk("overflow_cnt", 32'(overflow_cnt), 32'(ovf_mdl));
    chk("full_state_play", 32'(state), 32'd2);
    chk("xoff_still_valid", 32'(tx_valid), 32'(FC));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("xoff_accepted", 32'(tx_valid), 32'd0);

    v = pat(999, 5);
    send_byte(v[7:0]);
    send_byte(v[15:8]);
    rx_valid   = 1'b1;
    rx_byte    = v[23:16];
    sample_req = 1'b1;
    tick();
    rx_valid   = 1'b0;
    sample_req = 1'b0;
    e = exp_q.pop_front();
    exp_q.push_back(v);
    chk("full_pushpop_sample", 32'(sample_out), 32'(e));
    chk("full_pushpop_fill", 32'(fill_level), 32'(DEPTH));
    chk("full_pushpop_ovf", 32'(overflow_cnt), 32'(ovf_mdl));
    hold_v     = e;
    hold_valid = 1'b1;

    while (exp_q.size() > 97) pop_check(2);
    chk("no_tx_above_xon", 32'(tx_valid), 32'd0);
    pop_check(2);
    chk("fill_96", 32'(fill_level), 32'd96);
    tick();
    chk("xon_valid", 32'(tx_valid), 32'(FC));
    chk("xon_byte", 32'(tx_byte), FC ? 32'h11 : 32'h0);
    tick();
    chk("xon_valid_held", 32'(tx_valid), 32'(FC));
    tx_ready = 1'b1;
    tick();
    tx_ready = 1'b0;
    chk("xon_accepted", 32'(tx_valid), 32'd0);

    // ---------------- reset mid-play ----------------
    send_byte(8'h5A);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    exp_q.delete();
    hold_valid = 1'b0;
    chk_reset_vals("midplay_reset");

    for (int i = 0; i < 8; i++) begin
      rx_valid   = tbl[i].rxv;
      rx_byte    = tbl[i].b;
      sample_req = tbl[i].req;
      tick();
      rx_valid   = 1'b0;
      sample_req = 1'b0;
      chk($sformatf("vec%0d_fill", i), 32'(fill_level), 32'(tbl[i].fill));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(tbl[i].st));
      chk($sformatf("vec%0d_mute", i), 32'(mute), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
